// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: run/halt/step controller for the single-cycle RV32I core.
//
// The controller owns the core's commit enable. The host drives it through
// the command port to run the core freely, single-step it N instructions,
// halt it, manage one breakpoint and clear the commit counter. The core is
// also halted automatically when any of these is true for the fetched
// instruction:
//   - its PC is out of range
//   - it is a null word or a self-loop branch
//   - it sits on the breakpoint
//   - the commit budget is used up
//
// Parameters:
//   PC_LIMIT     first illegal PC; any pc >= PC_LIMIT halts the core
//   CYCLE_LIMIT  maximum number of commits, 0 = unlimited
//
// Ports:
//   clk           system clock, rising edge
//   rst           synchronous active-high reset
//   cmd_valid     host command present
//   cmd_ready     command accepted when valid && ready at a rising edge
//   cmd_op        command code (RUN/HALT/STEP/SETBP/CLRBP/CLRCNT, else NOP)
//   cmd_arg       STEP count or SETBP address
//   pc, instr     PC and instruction the core is currently presenting
//   cpu_en        commit enable for the current cycle
//   halted        controller is halted
//   halt_cause    reason for the most recent halt
//   commit_count  number of committed instructions (saturating)
module cpu_run_ctrl #(
  parameter logic [31:0] PC_LIMIT    = 32'h0000_0200,
  parameter logic [31:0] CYCLE_LIMIT = 32'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_op,
  input  logic [31:0] cmd_arg,
  input  logic [31:0] pc,
  input  logic [31:0] instr,
  output logic        cpu_en,
  output logic        halted,
  output logic [2:0]  halt_cause,
  output logic [31:0] commit_count
);

  typedef enum logic [1:0] {
    ST_HALT,
    ST_RUN,
    ST_STEP
  } state_t;

  localparam logic [2:0] OP_RUN    = 3'b001;
  localparam logic [2:0] OP_HALT   = 3'b010;
  localparam logic [2:0] OP_STEP   = 3'b011;
  localparam logic [2:0] OP_SETBP  = 3'b100;
  localparam logic [2:0] OP_CLRBP  = 3'b101;
  localparam logic [2:0] OP_CLRCNT = 3'b110;

  localparam logic [2:0] CAUSE_RESET = 3'd0;
  localparam logic [2:0] CAUSE_HOST  = 3'd1;
  localparam logic [2:0] CAUSE_STEP  = 3'd2;
  localparam logic [2:0] CAUSE_BP    = 3'd3;
  localparam logic [2:0] CAUSE_LOOP  = 3'd4;
  localparam logic [2:0] CAUSE_PCLIM = 3'd5;
  localparam logic [2:0] CAUSE_NULL  = 3'd6;
  localparam logic [2:0] CAUSE_CYCLE = 3'd7;

  localparam logic [31:0] SELF_LOOP_INSTR = 32'h0000_0063;

  state_t      state_q, state_d;
  logic [2:0]  cause_q, cause_d;
  logic [31:0] count_q, count_d;
  logic        bp_valid_q, bp_valid_d;
  logic [29:0] bp_addr_q, bp_addr_d;
  logic [31:0] step_rem_q, step_rem_d;
  logic        skip_bp_q, skip_bp_d;

  logic        stop_hit;
  logic [2:0]  stop_cause;
  logic        cmd_accept;

  // Commands stall while a step sequence is in flight so a STEP always
  // completes (or is cut short by a stop condition) before the host acts.
  assign cmd_ready  = (state_q != ST_STEP);
  assign cmd_accept = cmd_valid && cmd_ready;
  assign halted     = (state_q == ST_HALT);
  assign halt_cause = cause_q;
  assign commit_count = count_q;

  // Stop detection is pre-commit and looks only at registered state and the
  // core's fetch, never at the command port, so the core sees no path from
  // host commands to its commit enable. The if-chain encodes priority.
  always_comb begin
    stop_hit   = 1'b0;
    stop_cause = CAUSE_RESET;
    if (state_q != ST_HALT) begin
      if (pc >= PC_LIMIT) begin
        stop_hit   = 1'b1;
        stop_cause = CAUSE_PCLIM;
      end else if (instr == 32'd0) begin
        stop_hit   = 1'b1;
        stop_cause = CAUSE_NULL;
      end else if (instr == SELF_LOOP_INSTR) begin
        stop_hit   = 1'b1;
        stop_cause = CAUSE_LOOP;
      end else if (bp_valid_q && (pc[31:2] == bp_addr_q) && !skip_bp_q) begin
        stop_hit   = 1'b1;
        stop_cause = CAUSE_BP;
      end else if ((CYCLE_LIMIT != 32'd0) && (count_q >= CYCLE_LIMIT)) begin
        stop_hit   = 1'b1;
        stop_cause = CAUSE_CYCLE;
      end
    end
  end

  assign cpu_en = (state_q != ST_HALT) && !stop_hit;

  // Next-state logic. Stop conditions take precedence over a host HALT in
  // the same cycle so the more informative cause is kept. Breakpoint and
  // counter commands are applied last so CLRCNT beats a concurrent commit.
  always_comb begin
    state_d    = state_q;
    cause_d    = cause_q;
    count_d    = count_q;
    bp_valid_d = bp_valid_q;
    bp_addr_d  = bp_addr_q;
    step_rem_d = step_rem_q;
    skip_bp_d  = skip_bp_q;

    // The first commit after a resume consumes the breakpoint skip, so
    // resuming from a breakpoint executes that instruction exactly once.
    if (cpu_en) begin
      skip_bp_d = 1'b0;
      if (count_q != 32'hFFFF_FFFF) begin
        count_d = count_q + 32'd1;
      end
    end

    case (state_q)
      ST_HALT: begin
        if (cmd_accept && (cmd_op == OP_RUN)) begin
          state_d   = ST_RUN;
          skip_bp_d = 1'b1;
        end else if (cmd_accept && (cmd_op == OP_STEP)) begin
          state_d    = ST_STEP;
          step_rem_d = (cmd_arg == 32'd0) ? 32'd1 : cmd_arg;
          skip_bp_d  = 1'b1;
        end
      end
      ST_RUN: begin
        if (stop_hit) begin
          state_d = ST_HALT;
          cause_d = stop_cause;
        end else if (cmd_accept && (cmd_op == OP_HALT)) begin
          state_d = ST_HALT;
          cause_d = CAUSE_HOST;
        end
      end
      ST_STEP: begin
        if (stop_hit) begin
          state_d    = ST_HALT;
          cause_d    = stop_cause;
          step_rem_d = 32'd0;
        end else begin
          step_rem_d = step_rem_q - 32'd1;
          if (step_rem_q == 32'd1) begin
            state_d = ST_HALT;
            cause_d = CAUSE_STEP;
          end
        end
      end
      default: begin
        state_d = ST_HALT;
      end
    endcase

    if (cmd_accept) begin
      case (cmd_op)
        OP_SETBP: begin
          bp_valid_d = 1'b1;
          bp_addr_d  = cmd_arg[31:2];
        end
        OP_CLRBP: begin
          bp_valid_d = 1'b0;
        end
        OP_CLRCNT: begin
          count_d = 32'd0;
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_HALT;
      cause_q    <= CAUSE_RESET;
      count_q    <= 32'd0;
      bp_valid_q <= 1'b0;
      bp_addr_q  <= 30'd0;
      step_rem_q <= 32'd0;
      skip_bp_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cause_q    <= cause_d;
      count_q    <= count_d;
      bp_valid_q <= bp_valid_d;
      bp_addr_q  <= bp_addr_d;
      step_rem_q <= step_rem_d;
      skip_bp_q  <= skip_bp_d;
    end
  end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// tb_cpu_run_ctrl: testbench for cpu_run_ctrl.
//
// Two controllers share one command stream: dut0 has no commit budget, and
// dut1 uses CYCLE_LIMIT=5. The bench plays the core for each controller.
// It keeps a small program memory with optional jump targets and advances
// each PC whenever the reference model says that controller commits.
// Every cycle, each controller is compared against a behavioural model of
// the run/halt/step rules. Directed scenarios add fixed expected values on
// top of that.
module tb_cpu_run_ctrl;

  localparam logic [31:0] PLIM = 32'h0000_0200;
  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] LOOP = 32'h0000_0063;

  localparam logic [2:0] C_RUN = 3'b001, C_HALT = 3'b010, C_STEP = 3'b011;
  localparam logic [2:0] C_SETBP = 3'b100, C_CLRBP = 3'b101, C_CLRCNT = 3'b110;

  typedef struct {
    int          mode;   // 0 halted, 1 free running, 2 stepping
    logic [2:0]  cause;
    logic [31:0] count;
    logic        bpv;
    logic [31:0] bpa;
    logic [31:0] left;
    logic        skip;
  } mdl_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic [2:0]  cmd_op;
  logic [31:0] cmd_arg;
  logic [31:0] pc_v    [2];
  logic [31:0] instr_v [2];
  logic [1:0]  en_o, halted_o, ready_o;
  logic [2:0]  cause_o [2];
  logic [31:0] count_o [2];

  logic [31:0] climit [2];
  mdl_t        mdl [2];
  logic [31:0] prog [256];
  logic        jv   [256];
  logic [31:0] jt   [256];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always #5 clk = ~clk;

  cpu_run_ctrl #(.PC_LIMIT(PLIM), .CYCLE_LIMIT(32'd0)) dut0 (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(ready_o[0]),
    .cmd_op(cmd_op), .cmd_arg(cmd_arg), .pc(pc_v[0]), .instr(instr_v[0]),
    .cpu_en(en_o[0]), .halted(halted_o[0]), .halt_cause(cause_o[0]),
    .commit_count(count_o[0])
  );

  cpu_run_ctrl #(.PC_LIMIT(PLIM), .CYCLE_LIMIT(32'd5)) dut1 (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(ready_o[1]),
    .cmd_op(cmd_op), .cmd_arg(cmd_arg), .pc(pc_v[1]), .instr(instr_v[1]),
    .cpu_en(en_o[1]), .halted(halted_o[1]), .halt_cause(cause_o[1]),
    .commit_count(count_o[1])
  );

  function automatic logic [31:0] fetch(input logic [31:0] a);
    if (a[31:10] != 22'd0) return NOP;
    return prog[a[9:2]];
  endfunction

  function automatic logic [31:0] next_pc(input logic [31:0] a);
    if (a[31:10] == 22'd0 && jv[a[9:2]]) return jt[a[9:2]];
    return a + 32'd4;
  endfunction

  function automatic mdl_t mdl_reset();
    mdl_t m;
    m.mode = 0; m.cause = 3'd0; m.count = 32'd0; m.bpv = 1'b0;
    m.bpa = 32'd0; m.left = 32'd0; m.skip = 1'b0;
    return m;
  endfunction

  // One cycle of the controller's behaviour. It gives the commit enable
  // and ready flag for this cycle and the state after the clock edge.
  function automatic void mdl_cycle(input mdl_t m, input logic [31:0] p,
                                    input logic [31:0] ins, input logic [31:0] clim,
                                    output mdl_t n, output logic en, output logic rdy);
    int   why;
    logic acc;
    n   = m;
    rdy = (m.mode != 2);
    why = 0;
    if (m.mode != 0) begin
      if (p >= PLIM) why = 5;
      else if (ins == 32'd0) why = 6;
      else if (ins == LOOP) why = 4;
      else if (m.bpv && (p >> 2) == (m.bpa >> 2) && !m.skip) why = 3;
      else if (clim != 0 && m.count >= clim) why = 7;
    end
    en = (m.mode != 0) && (why == 0);
    if (rst) begin
      n = mdl_reset();
      return;
    end
    acc = cmd_valid && rdy;
    if (en) begin
      if (m.count != 32'hFFFF_FFFF) n.count = m.count + 1;
      n.skip = 1'b0;
    end
    if (why != 0) begin
      n.mode = 0; n.cause = 3'(why); n.left = 0;
    end else if (m.mode == 2) begin
      n.left = m.left - 1;
      if (m.left == 1) begin n.mode = 0; n.cause = 3'd2; end
    end
    if (acc) begin
      if (cmd_op == C_RUN && m.mode == 0) begin
        n.mode = 1; n.skip = 1'b1;
      end else if (cmd_op == C_STEP && m.mode == 0) begin
        n.mode = 2; n.skip = 1'b1; n.left = (cmd_arg == 0) ? 32'd1 : cmd_arg;
      end else if (cmd_op == C_HALT && m.mode == 1 && why == 0) begin
        n.mode = 0; n.cause = 3'd1;
      end else if (cmd_op == C_SETBP) begin
        n.bpv = 1'b1; n.bpa = cmd_arg;
      end else if (cmd_op == C_CLRBP) begin
        n.bpv = 1'b0;
      end else if (cmd_op == C_CLRCNT) begin
        n.count = 32'd0;
      end
    end
  endfunction

  // Advance one clock. Inputs are applied before the call. Outputs are
  // compared with the model, and then the bench core moves its PCs.
  task automatic step();
    mdl_t n [2];
    logic e_en [2];
    logic e_rdy;
    #1;
    for (int k = 0; k < 2; k++) begin
      mdl_cycle(mdl[k], pc_v[k], instr_v[k], climit[k], n[k], e_en[k], e_rdy);
      total += 5;
      if (en_o[k] !== e_en[k]) begin
        bad++; $display("[TB] FAIL cpu_en dut%0d cyc=%0d got=%b exp=%b", k, cyc, en_o[k], e_en[k]);
      end
      if (ready_o[k] !== e_rdy) begin
        bad++; $display("[TB] FAIL cmd_ready dut%0d cyc=%0d got=%b exp=%b", k, cyc, ready_o[k], e_rdy);
      end
      if (halted_o[k] !== (mdl[k].mode == 0)) begin
        bad++; $display("[TB] FAIL halted dut%0d cyc=%0d got=%b exp=%b", k, cyc, halted_o[k], mdl[k].mode == 0);
      end
      if (cause_o[k] !== mdl[k].cause) begin
        bad++; $display("[TB] FAIL halt_cause dut%0d cyc=%0d got=%0d exp=%0d", k, cyc, cause_o[k], mdl[k].cause);
      end
      if (count_o[k] !== mdl[k].count) begin
        bad++; $display("[TB] FAIL commit_count dut%0d cyc=%0d got=%0d exp=%0d", k, cyc, count_o[k], mdl[k].count);
      end
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      mdl[k] = n[k];
      if (rst) pc_v[k] = 32'd0;
      else if (e_en[k]) pc_v[k] = next_pc(pc_v[k]);
      instr_v[k] = fetch(pc_v[k]);
    end
    cmd_valid = 1'b0;
    cyc++;
    @(negedge clk);
  endtask

  task automatic send(input logic [2:0] op, input logic [31:0] arg);
    cmd_valid = 1'b1; cmd_op = op; cmd_arg = arg;
    step();
  endtask

  task automatic set_pc(input logic [31:0] a);
    for (int k = 0; k < 2; k++) begin
      pc_v[k] = a; instr_v[k] = fetch(a);
    end
  endtask

  task automatic load_nops();
    for (int i = 0; i < 256; i++) begin
      prog[i] = NOP; jv[i] = 1'b0; jt[i] = 32'd0;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic wait_halt(input int k, input int budget);
    int n = 0;
    while (halted_o[k] !== 1'b1 && n < budget) begin
      step(); n++;
    end
    total++;
    if (halted_o[k] !== 1'b1) begin
      bad++; $display("[TB] FAIL halt_timeout dut%0d got=running exp=halted within %0d cycles", k, budget);
    end
  endtask

  task automatic expect_state(input string tag, input int k, input logic [2:0] c,
                              input logic [31:0] cnt, input logic [31:0] p);
    total += 4;
    if (halted_o[k] !== 1'b1) begin
      bad++; $display("[TB] FAIL %s_halted got=%b exp=1", tag, halted_o[k]);
    end
    if (cause_o[k] !== c) begin
      bad++; $display("[TB] FAIL %s_cause got=%0d exp=%0d", tag, cause_o[k], c);
    end
    if (count_o[k] !== cnt) begin
      bad++; $display("[TB] FAIL %s_count got=%0d exp=%0d", tag, count_o[k], cnt);
    end
    if (pc_v[k] !== p) begin
      bad++; $display("[TB] FAIL %s_pc got=%h exp=%h", tag, pc_v[k], p);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 3'd0; cmd_arg = 32'd0;
    load_nops();
    set_pc(32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      mdl[k] = mdl_reset();
      total += 5;
      if (halted_o[k] !== 1'b1) begin bad++; $display("[TB] FAIL reset_halted dut%0d got=%b exp=1", k, halted_o[k]); end
      if (en_o[k] !== 1'b0) begin bad++; $display("[TB] FAIL reset_cpu_en dut%0d got=%b exp=0", k, en_o[k]); end
      if (ready_o[k] !== 1'b1) begin bad++; $display("[TB] FAIL reset_ready dut%0d got=%b exp=1", k, ready_o[k]); end
      if (cause_o[k] !== 3'd0) begin bad++; $display("[TB] FAIL reset_cause dut%0d got=%0d exp=0", k, cause_o[k]); end
      if (count_o[k] !== 32'd0) begin bad++; $display("[TB] FAIL reset_count dut%0d got=%0d exp=0", k, count_o[k]); end
    end
  endtask

  task automatic test_self_loop();
    load_nops(); prog[8] = LOOP;
    do_reset(); set_pc(32'd0);
    send(C_RUN, 32'd0);
    wait_halt(0, 100);
    expect_state("selfloop", 0, 3'd4, 32'd8, 32'h20);
  endtask

  task automatic test_breakpoint();
    load_nops(); prog[16] = LOOP;
    do_reset(); set_pc(32'd0);
    send(C_SETBP, 32'h13);
    send(C_RUN, 32'd0);
    wait_halt(0, 100);
    expect_state("bp_hit", 0, 3'd3, 32'd4, 32'h10);
    send(C_RUN, 32'd0);
    wait_halt(0, 100);
    expect_state("bp_resume", 0, 3'd4, 32'd16, 32'h40);
  endtask

  task automatic test_step();
    load_nops(); prog[16] = LOOP;
    do_reset(); set_pc(32'd0);
    send(C_STEP, 32'd3);
    for (int i = 0; i < 3; i++) begin
      total += 2;
      if (ready_o[0] !== 1'b0) begin bad++; $display("[TB] FAIL step_ready i=%0d got=%b exp=0", i, ready_o[0]); end
      if (en_o[0] !== 1'b1) begin bad++; $display("[TB] FAIL step_en i=%0d got=%b exp=1", i, en_o[0]); end
      cmd_valid = 1'b1; cmd_op = C_RUN; cmd_arg = 32'd0;
      step();
    end
    expect_state("step3", 0, 3'd2, 32'd3, 32'hC);
    send(C_STEP, 32'd0);
    total++;
    if (en_o[0] !== 1'b1) begin bad++; $display("[TB] FAIL step0_en got=%b exp=1", en_o[0]); end
    step();
    expect_state("step0", 0, 3'd2, 32'd4, 32'h10);
  endtask

  task automatic test_stop_causes();
    int n;
    load_nops(); jv[2] = 1'b1; jt[2] = 32'h200;
    do_reset(); set_pc(32'd0);
    send(C_RUN, 32'd0);
    n = 0;
    while (pc_v[0] != 32'h200 && n < 20) begin step(); n++; end
    total += 2;
    if (pc_v[0] !== 32'h200) begin bad++; $display("[TB] FAIL pclimit_reach got=%h exp=00000200", pc_v[0]); end
    if (en_o[0] !== 1'b0) begin bad++; $display("[TB] FAIL pclimit_en got=%b exp=0", en_o[0]); end
    step();
    expect_state("pclimit", 0, 3'd5, 32'd3, 32'h200);
    load_nops(); prog[16] = 32'd0;
    do_reset(); set_pc(32'h30);
    send(C_RUN, 32'd0);
    wait_halt(0, 100);
    expect_state("null", 0, 3'd6, 32'd4, 32'h40);
  endtask

  task automatic test_cycle_limit();
    load_nops(); prog[16] = LOOP;
    do_reset(); set_pc(32'd0);
    send(C_RUN, 32'd0);
    wait_halt(1, 100);
    expect_state("cyclimit", 1, 3'd7, 32'd5, 32'h14);
    wait_halt(0, 100);
    expect_state("nolimit", 0, 3'd4, 32'd16, 32'h40);
  endtask

  task automatic test_host_halt();
    load_nops(); prog[16] = LOOP;
    do_reset(); set_pc(32'd0);
    send(C_RUN, 32'd0);
    step(); step();
    send(C_HALT, 32'd0);
    expect_state("hosthalt", 0, 3'd1, 32'd3, 32'hC);
    load_nops(); prog[2] = LOOP;
    do_reset(); set_pc(32'd0);
    send(C_RUN, 32'd0);
    step(); step();
    send(C_HALT, 32'd0);
    expect_state("halt_vs_loop", 0, 3'd4, 32'd2, 32'h8);
  endtask

  task automatic test_clrcnt();
    load_nops(); prog[16] = LOOP;
    do_reset(); set_pc(32'd0);
    send(C_RUN, 32'd0);
    step(); step(); step();
    send(C_CLRCNT, 32'd0);
    total++;
    if (count_o[0] !== 32'd0) begin bad++; $display("[TB] FAIL clrcnt got=%0d exp=0", count_o[0]); end
    step();
    total++;
    if (count_o[0] !== 32'd1) begin bad++; $display("[TB] FAIL clrcnt_after got=%0d exp=1", count_o[0]); end
    wait_halt(0, 100);
  endtask

  task automatic test_reset_mid_step();
    int n;
    load_nops(); prog[16] = LOOP;
    do_reset(); set_pc(32'd0);
    send(C_SETBP, 32'h20);
    send(C_STEP, 32'd10);
    step(); step();
    rst = 1'b1; cmd_valid = 1'b1; cmd_op = C_RUN; cmd_arg = 32'd0;
    step();
    rst = 1'b0;
    total++;
    if (en_o[0] !== 1'b0) begin bad++; $display("[TB] FAIL rststep_en got=%b exp=0", en_o[0]); end
    expect_state("rststep", 0, 3'd0, 32'd0, 32'd0);
    send(C_RUN, 32'd0);
    n = 0;
    while (pc_v[0] != 32'h20 && n < 20) begin step(); n++; end
    total++;
    if (en_o[0] !== 1'b1) begin bad++; $display("[TB] FAIL rststep_bp_cleared got=%b exp=1", en_o[0]); end
    wait_halt(0, 100);
    expect_state("rststep_end", 0, 3'd4, 32'd16, 32'h40);
  endtask

  task automatic test_random();
    int r;
    for (int b = 0; b < 4; b++) begin
      for (int i = 0; i < 256; i++) begin
        r = $urandom_range(0, 99);
        prog[i] = (r < 3) ? LOOP : (r < 5) ? 32'd0 : NOP;
        jv[i]   = (r >= 5 && r < 11);
        jt[i]   = {22'd0, 8'($urandom_range(0, 159)), 2'b00};
      end
      for (int k = 0; k < 2; k++) instr_v[k] = fetch(pc_v[k]);
      for (int c = 0; c < 400; c++) begin
        for (int k = 0; k < 2; k++) begin
          if (mdl[k].mode == 0 && $urandom_range(0, 4) == 0) begin
            pc_v[k] = {22'd0, 8'($urandom_range(0, 159)), 2'b00};
            instr_v[k] = fetch(pc_v[k]);
          end
        end
        cmd_valid = ($urandom_range(0, 9) < 3);
        cmd_op    = 3'($urandom_range(0, 7));
        cmd_arg   = (cmd_op == C_STEP) ? 32'($urandom_range(0, 5))
                                       : 32'($urandom_range(0, 255));
        rst = ($urandom_range(0, 99) == 0);
        step();
        rst = 1'b0;
      end
    end
  endtask

  initial begin
    climit[0] = 32'd0;
    climit[1] = 32'd5;
    @(negedge clk);
    test_reset();
    test_self_loop();
    test_breakpoint();
    test_step();
    test_stop_causes();
    test_cycle_limit();
    test_host_halt();
    test_clrcnt();
    test_reset_mid_step();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
